// File: rtl/disp_pkg.sv
// Shared defaults and arbiter state type for the character-display memory arbiter.
package disp_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int DEPTH = 600;
   localparam int FIFO_DEPTH = 4;
   localparam logic [7:0] CLEAR_CHAR = 8'h20;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } arb_state_t;

endpackage

// File: rtl/disp_wr_fifo.sv
// Small synchronous FIFO holding posted {addr,data} writes for the display RAM.
module disp_wr_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic             one_left
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   logic [WIDTH-1:0] entries_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign one_left = (count_q == ONE_CNT);
   assign pop_data = entries_q[rd_ptr_q];

   // Next pointer and occupancy; a push into a full FIFO is refused, a pop from an empty one is ignored.
   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + ONE_CNT;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - ONE_CNT;
      end
   end

   // Pointer and occupancy registers; reset empties the buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset because occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         entries_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/disp_mem_arbiter.sv
// Arbitrates a single-port character RAM between scan-out reads (highest priority),
// posted vending-side writes, and a full-screen clear engine.
module disp_mem_arbiter #(
   parameter int ADDR_W = disp_pkg::ADDR_W,
   parameter int DATA_W = disp_pkg::DATA_W,
   parameter int DEPTH = disp_pkg::DEPTH,
   parameter int FIFO_DEPTH = disp_pkg::FIFO_DEPTH,
   parameter logic [DATA_W-1:0] CLEAR_CHAR = DATA_W'(disp_pkg::CLEAR_CHAR)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   import disp_pkg::*;

   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   arb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   logic              rd_p1_q, rd_p1_d;
   logic              rd_oob_q, rd_oob_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   logic              rd_hit_c;
   logic              wr_in_range_c;
   logic              wr_ready_c;
   logic              push_c;
   logic              pop_c;
   logic              clr_write_c;

   logic              mem_en_c;
   logic              mem_we_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [DATA_W-1:0] mem_wdata_c;

   logic [ADDR_W+DATA_W-1:0] fifo_head;
   logic [ADDR_W-1:0]        head_addr;
   logic [DATA_W-1:0]        head_data;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     fifo_one_left;

   assign head_addr = fifo_head[ADDR_W+DATA_W-1:DATA_W];
   assign head_data = fifo_head[DATA_W-1:0];

   disp_wr_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_c),
      .push_data ({wr_addr, wr_data}),
      .pop       (pop_c),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .one_left  (fifo_one_left)
   );

   // Decide who owns the RAM port this cycle: any read stalls writes and clear, even out-of-range ones.
   always_comb begin
      rd_hit_c      = rd_req && ({1'b0, rd_addr} < DEPTH_X);
      wr_in_range_c = ({1'b0, wr_addr} < DEPTH_X);
      wr_ready_c    = (state_q == IDLE) && !fifo_full;
      push_c        = wr_valid && wr_ready_c && wr_in_range_c;
      pop_c         = !rd_req && !fifo_empty && (state_q != CLEAR);
      clr_write_c   = !rd_req && (state_q == CLEAR);

      mem_en_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      if (rd_hit_c) begin
         mem_en_c   = 1'b1;
         mem_addr_c = rd_addr;
      end else if (pop_c) begin
         mem_en_c    = 1'b1;
         mem_we_c    = 1'b1;
         mem_addr_c  = head_addr;
         mem_wdata_c = head_data;
      end else if (clr_write_c) begin
         mem_en_c    = 1'b1;
         mem_we_c    = 1'b1;
         mem_addr_c  = clr_cnt_q;
         mem_wdata_c = CLEAR_CHAR;
      end
   end

   // Arbiter state machine: a clear first flushes pending posted writes, then sweeps every cell.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_start) begin
               state_d = (fifo_empty && !push_c) ? CLEAR : DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty || (pop_c && fifo_one_left)) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            if (clr_write_c) begin
               if (clr_cnt_q == LAST_ADDR) begin
                  state_d   = IDLE;
                  clr_cnt_d = '0;
               end else begin
                  clr_cnt_d = clr_cnt_q + ADDR_W'(1);
               end
            end
         end
         default: begin
            state_d   = IDLE;
            clr_cnt_d = '0;
         end
      endcase
   end

   // Two-stage read return: stage one marks the request, stage two captures RAM data or the fill code.
   always_comb begin
      rd_p1_d    = rd_req;
      rd_oob_d   = rd_req && !rd_hit_c;
      rd_valid_d = rd_p1_q;
      rd_data_d  = rd_data_q;
      if (rd_p1_q) begin
         rd_data_d = rd_oob_q ? CLEAR_CHAR : mem_rdata;
      end
   end

   // State, clear progress and read pipeline registers; reset drops any read in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         clr_cnt_q  <= '0;
         rd_p1_q    <= 1'b0;
         rd_oob_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         rd_p1_q    <= rd_p1_d;
         rd_oob_q   <= rd_oob_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // The RAM port is combinational from the arbitration decision, so it is forced idle while reset is held.
   assign mem_en    = mem_en_c && !reset;
   assign mem_we    = mem_we_c && !reset;
   assign mem_addr  = reset ? '0 : mem_addr_c;
   assign mem_wdata = reset ? '0 : mem_wdata_c;

   assign wr_ready = wr_ready_c && !reset;
   assign clr_busy = (state_q != IDLE);
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: doc/disp_mem_arbiter.md
DISP_MEM_ARBITER -- requirements
Module: disp_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W 10, char-RAM address width; DATA_W 8, character code width; DEPTH 600, valid cells (40x15 text grid); FIFO_DEPTH 4, posted-write buffer entries; CLEAR_CHAR 8'h20, fill code.
REQ-002 clk  input  1  single clock (25 MHz pixel domain); all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rd_req / rd_addr  input  1 / ADDR_W  scan-out read request and cell address; sampled every cycle.
REQ-005 rd_valid / rd_data  output  1 / DATA_W  read response.
REQ-006 wr_valid / wr_addr / wr_data  input  1 / ADDR_W / DATA_W  vending-side write request.
REQ-007 wr_ready  output  1  write accepted when wr_valid and wr_ready are both high.
REQ-008 clr_start  input  1  one-cycle pulse requesting full-screen clear.
REQ-009 clr_busy  output  1  high from the cycle after an accepted clr_start until the last clear write completes.
REQ-010 mem_en / mem_we / mem_addr / mem_wdata  output  1 / 1 / ADDR_W / DATA_W  single-port sync RAM port.
REQ-011 mem_rdata  input  DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we low.

Function
REQ-012 Reads SHALL have absolute priority: any cycle with rd_req high and rd_addr < DEPTH SHALL drive mem_en=1, mem_we=0, mem_addr=rd_addr.
REQ-013 rd_valid SHALL assert exactly 2 cycles after rd_req for every request, with rd_data registered from mem_rdata; back-to-back reads SHALL sustain 1 per cycle.
REQ-014 Reads with rd_addr >= DEPTH SHALL not access RAM and SHALL return CLEAR_CHAR with the same 2-cycle latency.
REQ-015 Writes SHALL be posted into a FIFO_DEPTH-entry FIFO; wr_ready = FIFO not full and state IDLE.
REQ-016 Accepted writes with wr_addr >= DEPTH SHALL be dropped (consumed, never issued to RAM).
REQ-017 In any cycle without a read, the FIFO head (if non-empty) SHALL be issued: mem_en=1, mem_we=1; FIFO order SHALL be preserved.
REQ-018 Simultaneous FIFO push and pop SHALL be permitted, including when full (push accepted only if not full at cycle start).
REQ-019 FSM states: IDLE, DRAIN, CLEAR.
REQ-020 IDLE: clr_start with FIFO empty -> CLEAR; clr_start with FIFO non-empty -> DRAIN.
REQ-021 DRAIN: wr_ready=0; pop as in REQ-017; FIFO empty -> CLEAR.
REQ-022 CLEAR: wr_ready=0; clear counter from 0 writes CLEAR_CHAR to address counter in each non-read cycle; after writing DEPTH-1 -> IDLE, counter reset to 0.
REQ-023 clr_start outside IDLE SHALL be ignored.
REQ-024 clr_busy SHALL be high in DRAIN and CLEAR, low in IDLE.
REQ-025 With continuous rd_req, writes and clear SHALL stall indefinitely without loss or corruption of state.

Reset
REQ-026 Reset SHALL force: state IDLE, FIFO empty, clear counter 0, rd_valid 0, rd_data 0, wr_ready 1 after release, clr_busy 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0.
REQ-027 Reset mid-clear or mid-drain SHALL abandon pending FIFO entries and clear progress; in-flight reads SHALL produce no rd_valid.

Structure
REQ-028 Package disp_pkg SHALL hold ADDR_W, DATA_W, DEPTH, CLEAR_CHAR defaults and the arb_state_t enum {IDLE, DRAIN, CLEAR}.
REQ-029 The posted-write buffer SHALL be sub-module disp_wr_fifo (sync FIFO, {addr,data} entries, full/empty flags, async active-high reset).

Verification
REQ-030 Read rd_addr=5 at cycle t with RAM[5]=8'h41 -> mem_en/we=1/0 addr 5 at t; rd_valid=1, rd_data=8'h41 at t+2.
REQ-031 rd_req held high 10 cycles while 4 writes posted -> wr_ready falls after 4th accept; no mem_we during reads; 4 writes issue in order in the 4 cycles after rd_req drops.
REQ-032 rd_addr=700 -> no mem_en; rd_data=8'h20 at t+2. Write to 650 -> accepted, never on RAM port.
REQ-033 2 writes pending then clr_start, no reads -> DRAIN 2 cycles, CLEAR 600 cycles writing 8'h20 to 0..599; clr_busy high 602 cycles; clr_start during busy ignored.
REQ-034 Clear with rd_req asserted every other cycle -> clear takes 1200 cycles, all reads return within 2 cycles, address sequence 0..599 gapless.
REQ-035 Assert reset at clear address 300 -> all outputs at REQ-026 values immediately; fresh clr_start restarts at address 0.
